// File: rtl/timer_counter_if.sv
// Bridge-to-timer bus: word address, write strobe/data, combinational read data and irq.
// dbg_state mirrors the timer FSM state for checkers.
interface timer_counter_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  dbg_state;

    // Handshake: no valid/ready; a write happens on every clock edge where we=1.
    // rdata and irq are combinational and valid in the same cycle as addr.
    modport master (
        output addr, we, wdata,
        input  rdata, irq, dbg_state
    );

    modport slave (
        input  addr, we, wdata,
        output rdata, irq, dbg_state
    );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer (CTRL / PRESET / COUNT).
// Optional macro TIMER_AUTORELOAD_EN enables MODE 01 auto-reload; otherwise every mode is one-shot.
module timer_counter (
    input  logic          clk,
    input  logic          reset_n,
    timer_counter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_flag;

    logic [1:0]  w_sel;
    logic        w_reload;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    assign w_sel         = bus.addr[3:2];
    assign w_unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

`ifdef TIMER_AUTORELOAD_EN
    assign w_reload = (r_ctrl[2:1] == 2'b01);
`else
    assign w_reload = 1'b0;
`endif

    // A write cycle updates registers only; the FSM and COUNT hold for that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ctrl   <= 4'd0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
            r_flag   <= 1'b0;
        end else if (bus.we) begin
            case (w_sel)
                2'd0:    r_ctrl   <= bus.wdata[3:0];
                2'd1:    r_preset <= bus.wdata;
                default: ;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_ctrl[0]) begin
                        r_state <= S_LOAD;
                        r_flag  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!r_ctrl[0]) begin
                        r_state <= S_IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count <= 32'd0;
                        r_flag  <= 1'b1;
                        r_state <= S_INT;
                    end
                end
                S_INT: begin
                    // One-shot keeps the flag until software re-enables.
                    if (w_reload) begin
                        r_flag <= 1'b0;
                    end else begin
                        r_ctrl[0] <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_sel)
            2'd0:    w_rdata = {28'd0, r_ctrl};
            2'd1:    w_rdata = r_preset;
            2'd2:    w_rdata = r_count;
            default: w_rdata = 32'd0;
        endcase
    end

    assign bus.rdata     = w_rdata;
    assign bus.irq       = r_ctrl[3] & r_flag;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: vector table for the one-shot count plus
// hand sequences for reset, auto-reload, small presets, masking and ignored writes.
module tb_timer_counter;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    logic [31:0] exp_q[$];

    timer_counter_if bus ();

    timer_counter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_count;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] c, input logic i);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.exp_count = c; v.exp_irq = i;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge with the given bus inputs; returns 1 time unit after the edge.
    task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.we = w; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h8, 32'h0);
    endtask

    task automatic read_chk(input logic [31:0] off, input logic [31:0] exp, input string name);
        logic [31:0] e;
        bus.addr = off;
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        check(name, bus.rdata, e);
    endtask

    task automatic irq_chk(input logic exp, input string name);
        logic [31:0] e;
        exp_q.push_back({31'd0, exp});
        e = exp_q.pop_front();
        check(name, {31'd0, bus.irq}, e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic exp_i;
        errors = 0;
        checks = 0;
        bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        read_chk(32'h0, 32'h0, "rst_ctrl");
        read_chk(32'h4, 32'h0, "rst_preset");
        read_chk(32'h8, 32'h0, "rst_count");
        irq_chk(1'b0, "rst_irq");
        check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // One-shot, PRESET=5, CTRL=0x9: E0 is the CTRL write.
        vecs[0]  = mk(1'b1, 32'h4, 32'd5, 32'd0, 1'b0);
        vecs[1]  = mk(1'b1, 32'h0, 32'h9, 32'd0, 1'b0);
        vecs[2]  = mk(1'b0, 32'h8, 32'h0, 32'd0, 1'b0);
        vecs[3]  = mk(1'b0, 32'h8, 32'h0, 32'd5, 1'b0);
        vecs[4]  = mk(1'b0, 32'h8, 32'h0, 32'd4, 1'b0);
        vecs[5]  = mk(1'b0, 32'h8, 32'h0, 32'd3, 1'b0);
        vecs[6]  = mk(1'b0, 32'h8, 32'h0, 32'd2, 1'b0);
        vecs[7]  = mk(1'b0, 32'h8, 32'h0, 32'd1, 1'b0);
        vecs[8]  = mk(1'b0, 32'h8, 32'h0, 32'd0, 1'b1);
        vecs[9]  = mk(1'b0, 32'h8, 32'h0, 32'd0, 1'b1);
        vecs[10] = mk(1'b0, 32'h8, 32'h0, 32'd0, 1'b1);
        foreach (vecs[i]) begin
            cycle(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            read_chk(32'h8, vecs[i].exp_count, $sformatf("os_count[%0d]", i));
            irq_chk(vecs[i].exp_irq, $sformatf("os_irq[%0d]", i));
        end
        read_chk(32'h0, 32'h8, "os_ctrl_en_cleared");
        read_chk(32'h4, 32'd5, "os_preset");

        // Reset mid-count: PRESET=100, COUNT reaches 50 at E52.
        do_reset();
        cycle(1'b1, 32'h4, 32'd100);
        cycle(1'b1, 32'h0, 32'h9);
        idle(52);
        read_chk(32'h8, 32'd50, "mid_count50");
        reset_n = 1'b0;
        #1;
        read_chk(32'h0, 32'h0, "mid_rst_ctrl");
        read_chk(32'h4, 32'h0, "mid_rst_preset");
        read_chk(32'h8, 32'h0, "mid_rst_count");
        read_chk(32'hC, 32'h0, "mid_rst_resv");
        irq_chk(1'b0, "mid_rst_irq");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // PRESET=3, CTRL=0xB: INT at E5, then every 6 cycles with auto-reload.
        cycle(1'b1, 32'h4, 32'd3);
        cycle(1'b1, 32'h0, 32'hB);
        for (int k = 1; k <= 14; k++) begin
            cycle(1'b0, 32'h8, 32'h0);
`ifdef TIMER_AUTORELOAD_EN
            exp_i = (k == 5) || (k == 11);
`else
            exp_i = (k >= 5);
`endif
            irq_chk(exp_i, $sformatf("ar_irq[E%0d]", k));
        end
`ifdef TIMER_AUTORELOAD_EN
        read_chk(32'h0, 32'hB, "ar_ctrl");
`else
        read_chk(32'h0, 32'hA, "ar_ctrl");
`endif

        // PRESET=0 and PRESET=1 both reach INT at E3.
        for (int p = 0; p < 2; p++) begin
            do_reset();
            cycle(1'b1, 32'h4, p);
            cycle(1'b1, 32'h0, 32'h9);
            idle(2);
            irq_chk(1'b0, $sformatf("p%0d_irq_E2", p));
            read_chk(32'h8, p, $sformatf("p%0d_count_E2", p));
            idle(1);
            irq_chk(1'b1, $sformatf("p%0d_irq_E3", p));
            read_chk(32'h8, 32'd0, $sformatf("p%0d_count_E3", p));
        end

        // IM=0: flag sets silently; setting IM raises irq without a recount.
        do_reset();
        cycle(1'b1, 32'h4, 32'd2);
        cycle(1'b1, 32'h0, 32'h1);
        idle(5);
        irq_chk(1'b0, "mask_irq_low");
        read_chk(32'h0, 32'h0, "mask_en_cleared");
        cycle(1'b1, 32'h0, 32'h9);
        irq_chk(1'b1, "mask_irq_unmasked");
        read_chk(32'h8, 32'd0, "mask_no_recount");
        idle(1);
        irq_chk(1'b0, "mask_flag_cleared_on_load");

        // Writes to COUNT and reserved offset stall the decrement only.
        do_reset();
        cycle(1'b1, 32'h4, 32'd10);
        cycle(1'b1, 32'h0, 32'h1);
        idle(3);
        read_chk(32'h8, 32'd9, "ign_count9");
        cycle(1'b1, 32'h8, 32'h1234);
        read_chk(32'h8, 32'd9, "ign_count_write");
        cycle(1'b1, 32'hC, 32'hFFFF_FFFF);
        read_chk(32'h8, 32'd9, "ign_resv_write");
        read_chk(32'hC, 32'd0, "ign_resv_read");
        idle(1);
        read_chk(32'h8, 32'd8, "ign_resume");

        // EN=0 during CNT freezes COUNT; re-enable reloads from PRESET.
        cycle(1'b1, 32'h0, 32'h0);
        read_chk(32'h8, 32'd8, "dis_write_hold");
        idle(3);
        read_chk(32'h8, 32'd8, "dis_frozen");
        check("dis_idle_state", {30'd0, bus.dbg_state}, 32'd0);
        cycle(1'b1, 32'h0, 32'h1);
        idle(2);
        read_chk(32'h8, 32'd10, "dis_reload");

        // Full-range preset decrements without wrap.
        do_reset();
        cycle(1'b1, 32'h4, 32'hFFFF_FFFF);
        cycle(1'b1, 32'h0, 32'h1);
        idle(2);
        read_chk(32'h8, 32'hFFFF_FFFF, "max_load");
        idle(1);
        read_chk(32'h8, 32'hFFFF_FFFE, "max_dec");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
